// File: rtl/seq_div_pkg.sv
// Shared arithmetic-datapath definitions: divider FSM encoding and default operand width.
package seq_div_pkg;

    // Default operand width, shared with the multiplier wrapper.
    localparam int unsigned ARITH_N = 32;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StCalc = 1'b1
    } divState_e;

endpackage

// File: rtl/seq_div_if.sv
// Start/busy/done handshake bundle between a divider and its requester.
interface seq_div_if
    import seq_div_pkg::*;
#(
    parameter int unsigned N = ARITH_N
) ();

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_div_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract D.
module seq_div_div_step #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] remIn,
    input  logic         bitIn,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] remOut,
    output logic         qBit
);

    logic [N:0] shifted;

    // Partial remainder is always below D, so the restored or reduced result fits in N bits.
    always_comb begin
        shifted = {remIn, bitIn};
        qBit    = (shifted >= {1'b0, divisor});
        remOut  = qBit ? (shifted[N-1:0] - divisor) : shifted[N-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, results held until the next done.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned N = ARITH_N
) (
    input  logic     clk,
    input  logic     reset,
    seq_div_if.slave bus
);

    localparam int unsigned CW = $clog2(N);

    divState_e    state;
    logic [CW-1:0] cnt;
    logic [N-1:0] remQ;      // partial remainder; its (N+1)th bit is always zero
    logic [N-1:0] shQ;       // dividend bits shifting out, quotient bits shifting in
    logic [N-1:0] divQ;
    logic         busyQ;
    logic         doneQ;
    logic [N-1:0] quotQ;
    logic [N-1:0] remOutQ;
    logic         dbzQ;

    logic [N-1:0] remNext;
    logic         qBit;

    seq_div_div_step #(
        .N(N)
    ) u_step (
        .remIn  (remQ),
        .bitIn  (shQ[N-1]),
        .divisor(divQ),
        .remOut (remNext),
        .qBit   (qBit)
    );

    // FSM, iteration counter, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= StIdle;
            cnt     <= '0;
            remQ    <= '0;
            shQ     <= '0;
            divQ    <= '0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
            quotQ   <= '0;
            remOutQ <= '0;
            dbzQ    <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.start) begin
                        divQ  <= bus.divisor;
                        remQ  <= '0;
                        shQ   <= bus.dividend;
                        cnt   <= CW'(N - 1);
                        busyQ <= 1'b1;
                        state <= StCalc;
                    end
                end
                StCalc: begin
                    if (divQ == '0) begin
                        // shQ still holds the untouched dividend here.
                        quotQ   <= '1;
                        remOutQ <= shQ;
                        dbzQ    <= 1'b1;
                        doneQ   <= 1'b1;
                        busyQ   <= 1'b0;
                        state   <= StIdle;
                    end else begin
                        remQ <= remNext;
                        shQ  <= {shQ[N-2:0], qBit};
                        if (cnt == '0) begin
                            quotQ   <= {shQ[N-2:0], qBit};
                            remOutQ <= remNext;
                            dbzQ    <= 1'b0;
                            doneQ   <= 1'b1;
                            busyQ   <= 1'b0;
                            state   <= StIdle;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy        = busyQ;
    assign bus.done        = doneQ;
    assign bus.quotient    = quotQ;
    assign bus.remainder   = remOutQ;
    assign bus.div_by_zero = dbzQ;

endmodule

// File: doc/seq_div.md
# seq_div

Sequential restoring divider, the inverse companion of the sequential multiplier: unsigned N-bit dividend ÷ N-bit divisor → N-bit quotient + N-bit remainder, one quotient bit per clock. Start/busy/done handshake; operands latched on accept, results held stable until the next accepted start. Sits beside the multiplier in the arithmetic datapath; intended for wrapping in the same input/output `regN` register shell.

## Interface
- `N`, 32, operand/result width (≥2)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `start`  in  1  request; accepted only when `busy`=0
- `dividend`  in  N  unsigned dividend, sampled on accept edge only
- `divisor`  in  N  unsigned divisor, sampled on accept edge only
- `busy`  out  1  high from accept edge until done edge
- `done`  out  1  one-cycle pulse, results valid
- `quotient`  out  N  unsigned quotient, held after done
- `remainder`  out  N  unsigned remainder, held after done
- `div_by_zero`  out  1  set with done if divisor was 0, held with results

## Operation
- States: IDLE, CALC. Registered outputs only.
- IDLE + `start`=1 → latch operands, clear partial remainder R (N+1 bits), load shift register Q←dividend, counter←N-1, go CALC, `busy`←1.
- If latched divisor = 0: skip iteration; next edge → IDLE, `quotient`←all ones, `remainder`←dividend, `div_by_zero`←1, `done` pulse.
- CALC iteration (restoring): T = {R[N-1:0], Q[N-1]} − {1'b0, D}; if T ≥ 0 (no borrow) R←T, shift 1 into Q; else R←{R[N-1:0], Q[N-1]}, shift 0 into Q. Counter decrements; at counter=0 the final iteration writes `quotient`←Q', `remainder`←R'[N-1:0], `div_by_zero`←0, `done`←1, `busy`←0, → IDLE.
- Subtraction width N+1 bits; no overflow possible for unsigned operands.
- `start` while `busy`=1 ignored; operand changes during CALC have no effect.
- `start`=1 in the `done` cycle is accepted (state already IDLE): back-to-back operation with no bubble.
- Results and `div_by_zero` change only on done edges or reset.
- Reset (any time, incl. mid-CALC): state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0; partial operation discarded, no `done` emitted.

## Timing
- Accept at edge k; iterations at edges k+1..k+N; `done`=1 in the cycle after edge k+N (latency N cycles from accept, 32 for default).
- Divide-by-zero: `done`=1 in the cycle after edge k+1.
- `busy` high during cycles after edges k..k+N-1; low in the `done` cycle.
- Throughput: one division per N cycles with back-to-back starts.
- Reset deassertion synchronous in effect: first accept possible at first rising edge after `reset` goes high.

## Structure
- Shared package `arith_pkg`: state encoding (IDLE=0, CALC=1), default width constant `ARITH_N`=32, shared with multiplier wrapper.
- One sub-module natural: `div_step` — combinational single restoring step (inputs R, next dividend bit, D; outputs R', quotient bit). Remainder of block: FSM, counter, registers.

## Test plan
- 100 ÷ 7 (N=32): start one cycle → `done` exactly 32 cycles later, `quotient`=14, `remainder`=2, `div_by_zero`=0, `busy` high for preceding 32 cycles.
- 0xFFFFFFFF ÷ 1 → `quotient`=0xFFFFFFFF, `remainder`=0; 5 ÷ 9 → `quotient`=0, `remainder`=5.
- 1234 ÷ 0 → `done` 1 cycle after accept, `quotient`=0xFFFFFFFF, `remainder`=1234, `div_by_zero`=1; next normal division clears `div_by_zero`.
- Back-to-back: 50÷3 then `start` held in `done` cycle with 81÷9 → first 16 r2, second `done` 32 cycles later with 9 r0; `start` pulses and operand changes during `busy` ignored.
- Reset asserted at iteration 10 of 1000÷3 → all outputs 0 immediately (async), no `done`; after release, 1000÷3 → 333 r1.
- Random regression (≥10k pairs incl. 0, 1, max, divisor>dividend) vs reference model `q=a/b`, `r=a%b`.
